muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for MULT, MULTU, DIV and DIVU. It sits beside the ALU in the execute stage and takes the same source operands (srca/srcb). The controller muxes its HI/LO outputs into the writeback result path for MFHI/MFLO. The controller starts an operation and stalls on `busy`; results land in HI/LO after a fixed 33-cycle busy window.

## Interface
- `WIDTH`, 32, operand and HI/LO width; only 32 is supported.

- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `start` in 1: launch an operation; sampled only when idle.
- `op` in 2: operation, `muldiv_op_t`: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a` in 32: multiplicand or dividend (rs).
- `b` in 32: multiplier or divisor (rt).
- `hi_we` in 1: MTHI write strobe.
- `lo_we` in 1: MTLO write strobe.
- `wdata` in 32: MTHI/MTLO data (rs).
- `busy` out 1: operation in flight; the controller stalls while high.
- `done` out 1: one-cycle pulse, HI/LO freshly updated.
- `divzero` out 1: last accepted op was DIV/DIVU with b==0; valid from `done`, held until the next accepted start.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- FSM states and transitions:
  - IDLE → RUN on `start`.
  - RUN, 5-bit counter 0..31 → FIX after count 31.
  - FIX → IDLE.
- **Accept (IDLE, start=1):**
  - Latch op.
  - Latch |a| and |b| for signed ops. abs(0x80000000) = 0x80000000 as unsigned.
  - Record result sign and remainder sign.
  - Clear the 64-bit accumulator.
- **Multiply:** radix-2 shift-add, one multiplier bit per RUN cycle, 64-bit unsigned product.
- **Divide:** restoring, one quotient bit per RUN cycle, 32-bit unsigned quotient and remainder.
- **FIX:**
  - Multiply: negate the 64-bit product if the operand signs differ (signed only). HI = product[63:32], LO = product[31:0].
  - Divide: negate the quotient if the signs differ. The remainder takes the dividend's sign. LO = quotient, HI = remainder.
- **Division by zero:**
  - HI = a (original, unmodified), LO = 0xFFFFFFFF, `divzero` = 1.
  - Applies to both DIV and DIVU.
  - Still takes the full 33 busy cycles.
- **DIV 0x80000000 / 0xFFFFFFFF:** LO = 0x80000000, HI = 0. This falls out of the unsigned core plus fix-up; no special case.
- **MTHI/MTLO:**
  - In IDLE, the register takes `wdata` at the edge.
  - While busy, the strobes are ignored.
- **Simultaneous start and hi_we/lo_we in IDLE:** start wins and the write is dropped.
- **Start while busy:** ignored, no queueing.
- **Reset (any state, including mid-operation):**
  - State IDLE, counter 0.
  - `hi` = `lo` = 0.
  - `busy` = `done` = `divzero` = 0.

## Timing
- Cycle 0: `start` high and sampled at the end of cycle 0.
- Cycles 1–33: `busy` = 1, 33 cycles. Iterations run at the ends of cycles 1–32; fix-up runs at the end of cycle 33.
- Cycle 34:
  - `hi`/`lo` show the new values.
  - `done` = 1 for exactly one cycle.
  - `busy` = 0.
  - A new `start` is accepted, so back-to-back ops are legal.
- `hi`/`lo` do not change during cycles 1–33; they are registered outputs.
- MTHI/MTLO latency: one cycle (write at the edge, visible the next cycle).
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `mips_pkg`:
  - `muldiv_op_t` (2-bit enum).
  - `MULDIV_CYCLES` = 33.
  - `MULDIV_STATE_t` (IDLE/RUN/FIX).
- No sub-module. The shift-add and restoring datapath share one 64-bit accumulator inside `muldiv_unit`.
- Expected size: about 200 lines.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001; `done` in cycle 34; `busy` high exactly in cycles 1–33.
- MULT 0xFFFFFFFD (−3) × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. MULT 0x80000000 × 0x80000000 → HI = 0x40000000, LO = 0.
- DIV 0xFFFFFFF9 (−7) / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 7 / 2 → LO = 3, HI = 1.
- DIVU 7 / 0 → HI = 7, LO = 0xFFFFFFFF, `divzero` = 1. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0, `divzero` = 0.
- Edge cases:
  - MTHI 0x1234 in IDLE → `hi` = 0x1234 the next cycle.
  - MTLO during busy → ignored.
  - `start` during busy → ignored, and the result matches the first op.
  - `start` with `hi_we` in IDLE → op runs and the write is dropped.
- Reset at cycle 15 of a DIV → the next cycle has `busy` = 0, `hi` = `lo` = 0, `done` = 0. A new MULTU 3 × 5 then yields LO = 15 with normal latency.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS execute-stage helpers.
package mips_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } MULDIV_STATE_t;

    localparam int MULDIV_CYCLES = 33;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide with HI/LO: 32 shift-add or restoring
// iterations on magnitudes, then one sign fix-up cycle.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  muldiv_op_t       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int AW = 2 * WIDTH;

    MULDIV_STATE_t    state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             divzero_q, divzero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    muldiv_op_t       op_q, op_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] aorig_q, aorig_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic [AW-1:0]    acc_q, acc_d;

    logic             is_signed_in;
    logic             is_div;
    logic [AW-1:0]    mul_next;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;
    logic             div_ok;
    logic [AW-1:0]    div_next;
    logic [AW-1:0]    prod_fix;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        divzero_d = divzero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        op_d      = op_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        aorig_d   = aorig_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        acc_d     = acc_q;

        is_signed_in = ~op[0];
        is_div       = op_q[1];

        // Both cores consume operand bits MSB first; ~cnt_q is 31-cnt_q.
        mul_next = {acc_q[AW-2:0], 1'b0} + {{WIDTH{1'b0}}, (opb_q[~cnt_q] ? opa_q : '0)};
        rem_sh   = {acc_q[AW-1:WIDTH], opa_q[~cnt_q]};
        diff     = {1'b0, rem_sh} - {2'b00, opb_q};
        div_ok   = ~diff[WIDTH+1];
        div_next = {(div_ok ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ok};
        prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    divzero_d = 1'b0;
                    op_d      = op;
                    opa_d     = cond_neg(a, is_signed_in & a[WIDTH-1]);
                    opb_d     = cond_neg(b, is_signed_in & b[WIDTH-1]);
                    aorig_d   = a;
                    neg_res_d = is_signed_in & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = is_signed_in & a[WIDTH-1];
                    acc_d     = '0;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            RUN: begin
                acc_d = is_div ? div_next : mul_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (!is_div) begin
                    hi_d = prod_fix[AW-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (opb_q == '0) begin
                    hi_d      = aorig_q;
                    lo_d      = '1;
                    divzero_d = 1'b1;
                end else begin
                    lo_d = cond_neg(acc_q[WIDTH-1:0], neg_res_q);
                    hi_d = cond_neg(acc_q[AW-1:WIDTH], neg_rem_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Operand and accumulator registers are always reloaded on accept.
    always_ff @(posedge clk) begin
        op_q      <= op_d;
        opa_q     <= opa_d;
        opb_q     <= opb_d;
        aorig_q   <= aorig_d;
        neg_res_q <= neg_res_d;
        neg_rem_q <= neg_rem_d;
        acc_q     <= acc_d;
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign divzero = divzero_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit with hand-computed HI/LO results.
module tb_muldiv_unit;
    import mips_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    muldiv_op_t  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        divzero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int failures;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .divzero (divzero),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Runs one operation from a negedge; optionally disturbs it mid-flight
    // (start + MTLO while busy) or asserts MTHI together with start.
    task automatic do_op(input string tag, input logic [1:0] o,
                         input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edz, input bit poke, input bit wr_start);
        int          nbusy;
        int          nchg;
        logic [31:0] hi_pre;
        logic [31:0] lo_pre;
        nbusy  = 0;
        nchg   = 0;
        hi_pre = hi;
        lo_pre = lo;
        op     = muldiv_op_t'(o);
        a      = av;
        b      = bv;
        start  = 1'b1;
        if (wr_start) begin
            hi_we = 1'b1;
            wdata = 32'h0000BEEF;
        end
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        for (int i = 0; i < MULDIV_CYCLES; i++) begin
            if (busy && !done) nbusy++;
            if (hi !== hi_pre || lo !== lo_pre) nchg++;
            if (poke && i == 10) begin
                start = 1'b1;
                op    = OP_MULTU;
                a     = 32'hFFFFFFFF;
                b     = 32'hFFFFFFFF;
                lo_we = 1'b1;
                wdata = 32'h0000DEAD;
            end
            if (poke && i == 11) begin
                start = 1'b0;
                lo_we = 1'b0;
            end
            @(negedge clk);
        end
        check({tag, "_busycyc"}, 64'(nbusy), 64'd33);
        check({tag, "_hold"}, 64'(nchg), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy34"}, 64'(busy), 64'd0);
        check({tag, "_hi"}, 64'(hi), 64'(ehi));
        check({tag, "_lo"}, 64'(lo), 64'(elo));
        check({tag, "_dz"}, 64'(divzero), 64'(edz));
        @(negedge clk);
        check({tag, "_done1"}, 64'(done), 64'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        start    = 1'b0;
        op       = OP_MULT;
        a        = '0;
        b        = '0;
        hi_we    = 1'b0;
        lo_we    = 1'b0;
        wdata    = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dz", 64'(divzero), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        reset = 1'b1;

        hi_we = 1'b1;
        wdata = 32'h00001234;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi", 64'(hi), 64'h1234);
        lo_we = 1'b1;
        wdata = 32'h00005678;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo", 64'(lo), 64'h5678);
        check("mtlo_hi_kept", 64'(hi), 64'h1234);

        do_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, 1'b0);
        do_op("mult_neg", 2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0, 1'b0);
        do_op("mult_min", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 1'b0);
        do_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0);
        do_op("divu", 2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0, 1'b0, 1'b0);
        do_op("divu_zero", 2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        do_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0, 1'b0);
        do_op("busy_poke", 2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 1'b1, 1'b0);

        op    = OP_DIV;
        a     = 32'h00000064;
        b     = 32'h00000007;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        do_op("after_rst", 2'b01, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, 1'b0, 1'b0, 1'b0);
        do_op("start_wr", 2'b01, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
